// File: rtl/reglist_encoder.sv
// Register-list encoder: walks a latched 16-bit register mask and issues one
// register number per accepted transfer, in ascending or descending order.
module reglist_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        up,
  input  logic [15:0] reglist,
  input  logic        ready,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  regnum,
  output logic [4:0]  index,
  output logic [4:0]  total,
  output logic        last,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic        up_q, up_d;
  logic [4:0]  index_q, index_d;
  logic [4:0]  total_q, total_d;

  logic [3:0]  enc;
  logic        one_left;
  logic [4:0]  list_count;

  // Priority encode of the pending mask; loop order picks lowest or highest.
  always_comb begin
    enc = '0;
    if (up_q) begin
      for (int unsigned i = 16; i > 0; i--) begin
        if (mask_q[i-1]) enc = 4'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (mask_q[i]) enc = 4'(i);
      end
    end
  end

  always_comb begin
    list_count = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      list_count = list_count + 5'(reglist[i]);
    end
  end

  assign one_left = (mask_q != '0) && ((mask_q & (mask_q - 16'd1)) == '0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    up_d    = up_q;
    index_d = index_q;
    total_d = total_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = reglist;
          up_d    = up;
          total_d = list_count;
          index_d = '0;
          state_d = (reglist != '0) ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        if (ready) begin
          mask_d  = mask_q & ~(16'd1 << enc);
          index_d = index_q + 5'd1;
          if (one_left) state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      up_q    <= 1'b1;
      index_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      up_q    <= up_d;
      index_q <= index_d;
      total_q <= total_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign valid  = (state_q == ISSUE);
  assign regnum = valid ? enc : '0;
  assign index  = valid ? index_q : '0;
  assign total  = total_q;
  assign last   = valid && one_left;
  assign done   = (state_q == FINISH);

endmodule

// File: tb/tb_reglist_encoder.sv
// Scoreboard bench for reglist_encoder: expected entries are queued at start
// and popped as transfers complete.
module tb_reglist_encoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        up;
  logic [15:0] reglist;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [3:0]  regnum;
  logic [4:0]  index;
  logic [4:0]  total;
  logic        last;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] rn;
    logic [4:0] ix;
    logic       lst;
  } exp_t;

  exp_t sb[$];

  reglist_encoder dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .up      (up),
    .reglist (reglist),
    .ready   (ready),
    .busy    (busy),
    .valid   (valid),
    .regnum  (regnum),
    .index   (index),
    .total   (total),
    .last    (last),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    start   = 1'b1;
    up      = 1'b0;
    reglist = 16'hFFFF;
    ready   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      checks++;
      if ({busy, valid, regnum, index, total, last, done} !== 18'd0) begin
        errors++;
        $display("FAIL reset_outputs: got busy=%b valid=%b regnum=%0d index=%0d total=%0d last=%b done=%b, want all 0",
                 busy, valid, regnum, index, total, last, done);
      end
    end
    start = 1'b0;
    ready = 1'b0;
    reset = 1'b1;
    next_cycle();
  endtask

  // toggle: ready is 0 on odd cycles after start, 1 on even ones.
  // inject: a conflicting start is asserted mid-sequence and must be ignored.
  task automatic run_seq(input logic [15:0] list, input logic dir,
                         input bit toggle, input bit inject, input string name);
    int   n;
    int   ix;
    int   exp_done;
    bit   seen_done;
    exp_t e;
    sb.delete();
    n = 0;
    for (int k = 0; k < 16; k++) if (list[k]) n++;
    ix = 0;
    for (int k = 0; k < 16; k++) begin
      int b;
      b = dir ? k : 15 - k;
      if (list[b]) begin
        e.rn  = 4'(b);
        e.ix  = 5'(ix);
        e.lst = (ix == n - 1);
        sb.push_back(e);
        ix++;
      end
    end
    exp_done = toggle ? 2 * n + 1 : n + 1;

    start   = 1'b1;
    reglist = list;
    up      = dir;
    next_cycle();
    start   = 1'b0;
    reglist = 16'(~list);
    up      = ~dir;
    seen_done = 1'b0;

    for (int c = 1; c <= 60 && !seen_done; c++) begin
      if (done) begin
        checks++;
        if (c != exp_done || valid !== 1'b0 || sb.size() != 0) begin
          errors++;
          $display("FAIL %s_done: got done at cycle %0d valid=%b pending=%0d, want cycle %0d valid=0 pending=0",
                   name, c, valid, sb.size(), exp_done);
        end
        checks++;
        if (total !== 5'(n)) begin
          errors++;
          $display("FAIL %s_total_at_done: got %0d, want %0d", name, total, n);
        end
        seen_done = 1'b1;
      end else if (valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_valid: got regnum=%0d at cycle %0d, want no more entries", name, regnum, c);
        end else if (regnum !== sb[0].rn || index !== sb[0].ix || last !== sb[0].lst ||
                     total !== 5'(n) || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_entry: got regnum=%0d index=%0d last=%b total=%0d busy=%b, want regnum=%0d index=%0d last=%b total=%0d busy=1",
                   name, regnum, index, last, total, busy, sb[0].rn, sb[0].ix, sb[0].lst, n);
        end
      end else begin
        checks++;
        if (regnum !== 4'd0 || index !== 5'd0 || last !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_gap: got busy=%b regnum=%0d index=%0d last=%b at cycle %0d, want busy=1 and zeros",
                   name, busy, regnum, index, last, c);
        end
      end
      ready = toggle ? ((c % 2) == 0) : 1'b1;
      if (valid && ready && sb.size() != 0) void'(sb.pop_front());
      if (inject && c == 2) begin
        start   = 1'b1;
        reglist = 16'hFFFF;
        up      = ~dir;
      end
      if (inject && c == 3) start = 1'b0;
      next_cycle();
    end
    start = 1'b0;
    ready = 1'b0;
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within 60 cycles, want done at cycle %0d", name, exp_done);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: got busy=%b done=%b valid=%b, want 0 0 0", name, busy, done, valid);
    end
  endtask

  task automatic test_ascending();
    run_seq(16'h8421, 1'b1, 1'b0, 1'b0, "ascending");
  endtask

  task automatic test_descending_backpressure();
    run_seq(16'h0013, 1'b0, 1'b1, 1'b0, "descending_bp");
  endtask

  task automatic test_empty_full();
    run_seq(16'h0000, 1'b1, 1'b0, 1'b0, "empty");
    run_seq(16'hFFFF, 1'b1, 1'b0, 1'b0, "full_up");
    run_seq(16'hFFFF, 1'b0, 1'b1, 1'b0, "full_down_bp");
  endtask

  task automatic test_ignored_start();
    run_seq(16'h8421, 1'b1, 1'b0, 1'b1, "ignored_start");
  endtask

  task automatic test_single();
    run_seq(16'h0200, 1'b1, 1'b0, 1'b0, "single_up");
    run_seq(16'h0200, 1'b0, 1'b1, 1'b0, "single_down");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      logic [15:0] l;
      l = 16'($urandom);
      run_seq(l, 1'($urandom), 1'(t % 2), 1'b0, "random");
    end
  endtask

  task automatic test_reset_abort();
    start   = 1'b1;
    reglist = 16'h00F0;
    up      = 1'b1;
    ready   = 1'b1;
    next_cycle();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || regnum !== 4'd4) begin
      errors++;
      $display("FAIL abort_first: got valid=%b regnum=%0d, want valid=1 regnum=4", valid, regnum);
    end
    next_cycle();
    checks++;
    if (valid !== 1'b1 || regnum !== 4'd5 || index !== 5'd1) begin
      errors++;
      $display("FAIL abort_second: got valid=%b regnum=%0d index=%0d, want valid=1 regnum=5 index=1", valid, regnum, index);
    end
    reset = 1'b0;
    next_cycle();
    checks++;
    if ({busy, valid, regnum, index, total, last, done} !== 18'd0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b valid=%b regnum=%0d index=%0d total=%0d last=%b done=%b, want all 0",
               busy, valid, regnum, index, total, last, done);
    end
    start   = 1'b1;
    reglist = 16'h00FF;
    next_cycle();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got busy=%b done=%b, want 0 0", busy, done);
    end
    reset   = 1'b1;
    reglist = 16'h0200;
    up      = 1'b0;
    next_cycle();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || regnum !== 4'd9 || last !== 1'b1 || index !== 5'd0 || total !== 5'd1) begin
      errors++;
      $display("FAIL restart_after_reset: got valid=%b regnum=%0d last=%b index=%0d total=%0d, want 1 9 1 0 1",
               valid, regnum, last, index, total);
    end
    next_cycle();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: got done=%b valid=%b, want done=1 valid=0", done, valid);
    end
    ready = 1'b0;
    next_cycle();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  initial begin
    start   = 1'b0;
    up      = 1'b1;
    reglist = '0;
    ready   = 1'b0;
    reset   = 1'b0;
    test_reset();
    test_ascending();
    test_descending_backpressure();
    test_empty_full();
    test_ignored_start();
    test_single();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reglist_encoder.md
REGLIST_ENCODER -- requirements
Module: reglist_encoder

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- start  input  1  request to begin encoding a register list.
- up  input  1  order select: 1 = ascending (bit 0 first), 0 = descending (bit 15 first).
- reglist  input  16  one-hot-per-register list; bit i set = register i selected.
- ready  input  1  consumer accepts the current regnum this cycle.
- busy  output  1  high whenever the state is not IDLE.
- valid  output  1  regnum/index/last are meaningful.
- regnum  output  4  register number of the current entry.
- index  output  5  zero-based position of the current entry in the transfer sequence.
- total  output  5  popcount of the latched list, range 0..16.
- last  output  1  current entry is the final one.
- done  output  1  one-cycle pulse at the end of the sequence.

Function
REQ-002 The block SHALL implement a three-state FSM with states IDLE, ISSUE and FINISH.
REQ-003 In IDLE with start=1, the block SHALL latch reglist into a 16-bit pending mask, latch up, load total with popcount(reglist), clear index, and go to ISSUE if the mask is non-zero, else to FINISH.
REQ-004 start SHALL be ignored in ISSUE and FINISH; the latched list and order SHALL NOT change until the block returns to IDLE.
REQ-005 In ISSUE, valid SHALL be 1 and regnum SHALL be the lowest set pending bit when up=1, or the highest set pending bit when up=0; this is a combinational priority encode of the registered mask.
REQ-006 A transfer SHALL occur on a cycle with valid=1 and ready=1; on that edge the encoded bit SHALL be cleared from the mask and index SHALL increment by 1.
REQ-007 While ready=0, regnum, index, last and the mask SHALL hold stable.
REQ-008 last SHALL equal valid AND (the mask has exactly one set bit); equivalently index == total-1.
REQ-009 A transfer with last=1 SHALL move the FSM to FINISH; a transfer with last=0 SHALL keep it in ISSUE with the next entry presented on the following cycle, with no bubble.
REQ-010 In FINISH, done SHALL be 1 for exactly one cycle, valid SHALL be 0, and the next state SHALL be IDLE.
REQ-011 Empty list: start with reglist=0 SHALL give total=0, no valid cycle, and done one cycle after start.
REQ-012 Latency SHALL be: start in IDLE at edge N, first valid in cycle N+1, done in the cycle after the last transfer. A full list with ready held high SHALL take 16 valid cycles plus 1 done cycle.
REQ-013 valid, done and last SHALL be 0 in IDLE; regnum and index SHALL be 0 whenever valid=0.
REQ-014 total and index SHALL never exceed 16; index SHALL never wrap.

Reset
REQ-015 When reset=0 at a rising clk edge, the block SHALL enter IDLE and clear the mask, index, total and the latched order; the latched order SHALL reset to up=1.
REQ-016 During and after reset, all outputs (busy, valid, regnum, index, total, last, done) SHALL be 0.
REQ-017 Reset mid-sequence SHALL abort immediately with no done pulse; start SHALL be accepted on the first edge with reset=1.
REQ-018 Reset SHALL take priority over start and ready on the same edge.

Verification
REQ-019 Ascending: reglist=16'h8421, up=1, ready=1 -> regnum 0,5,10,15 on consecutive cycles; index 0..3; total=4; last only with 15; then done for 1 cycle, then busy=0.
REQ-020 Descending with backpressure: reglist=16'h0013, up=0, ready toggling 0/1 -> regnum 4,1,0 in order; each value held while ready=0; last with 0; done after the third transfer.
REQ-021 Empty and full lists: reglist=0 -> total=0, valid never 1, done at cycle N+1; reglist=16'hFFFF with up=1 and ready=1 -> regnum 0..15, total=16, done at cycle N+17.
REQ-022 Ignored start: assert start with a new list while busy -> the sequence continues with the original list and order unchanged.
REQ-023 Reset abort: reset=0 during the second transfer of a 4-entry list -> all outputs 0 next cycle, no done pulse; a new start after reset is processed normally.
REQ-024 Single entry: reglist=16'h0200 -> regnum=9 with valid=1 and last=1 in the same cycle, index=0, total=1.
